// File: rtl/led_pkg.sv
// Shared encodings for the LED driver: command modes, breathe FSM states and defaults.
// The breathe ramp is compiled in only when LED_DRIVER_BREATHE_EN is defined.
package led_pkg;

    typedef enum logic [1:0] {
        ModeOff     = 2'b00,
        ModeOn      = 2'b01,
        ModeBlink   = 2'b10,
        ModeBreathe = 2'b11
    } mode_e;

    typedef enum logic {
        StRise = 1'b0,
        StFall = 1'b1
    } breathe_st_e;

    localparam int unsigned DefaultPwmBits = 8;

    // Integer prescaler division; a zero quotient would stall the tick, so clamp to 1.
    function automatic int unsigned clamp_div(input int unsigned num, input int unsigned den);
        int unsigned q;
        q = (den == 0) ? 0 : num / den;
        return (q == 0) ? 1 : q;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: emits a one-cycle tick every DIV cycles, restartable via i_clr.
module tick_gen #(
    parameter int unsigned DIV = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam int unsigned Div  = (DIV == 0) ? 1 : DIV;
    localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
    localparam logic [CntW-1:0] Last = CntW'(Div - 1);

    logic [CntW-1:0] r_cnt;
    logic            w_wrap;

    assign w_wrap = (r_cnt == Last);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A clear restarts the period, so it must not also count as a tick.
    assign o_tick = w_wrap && !i_clr;

endmodule

// File: rtl/led_driver.sv
// PWM LED driver with OFF/ON/BLINK/BREATHE modes; commands take effect at PWM period boundaries.
// Define LED_DRIVER_BREATHE_EN to build the breathe ramp; otherwise mode 11 behaves as ON.
module led_driver
    import led_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 25_000_000,
    parameter int unsigned PWM_BITS = DefaultPwmBits,
    parameter int unsigned BLINK_HZ = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic [1:0]          i_cmd_mode,
    input  logic [PWM_BITS-1:0] i_cmd_level,
    output logic                o_led
);

    localparam int unsigned BlinkDiv = clamp_div(CLK_FREQ, 2 * BLINK_HZ);
    localparam logic [PWM_BITS-1:0] CntLast = {{(PWM_BITS - 1){1'b1}}, 1'b0};

    logic [PWM_BITS-1:0] r_cnt;
    logic                r_pend;
    mode_e               r_pend_mode;
    logic [PWM_BITS-1:0] r_pend_level;
    mode_e               r_mode;
    logic [PWM_BITS-1:0] r_level;
    logic                r_phase;
    logic                r_led;

    logic                w_apply;
    logic                w_accept;
    logic                w_blink_tick;
    logic [PWM_BITS-1:0] w_duty;
    logic [PWM_BITS-1:0] w_breathe_duty;
    logic                w_led_d;

    assign o_cmd_ready = ~r_pend;
    assign o_led       = r_led;
    assign w_accept    = i_cmd_valid && o_cmd_ready;
    assign w_apply     = r_pend && (r_cnt == CntLast);

    tick_gen #(
        .DIV(BlinkDiv)
    ) u_blink_tick (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (w_apply),
        .o_tick(w_blink_tick)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt        <= '0;
            r_pend       <= 1'b0;
            r_pend_mode  <= ModeOff;
            r_pend_level <= '0;
            r_mode       <= ModeOff;
            r_level      <= '0;
            r_phase      <= 1'b1;
            r_led        <= 1'b0;
        end else begin
            r_cnt <= (r_cnt == CntLast) ? '0 : r_cnt + 1'b1;
            r_led <= w_led_d;
            if (w_apply) begin
                r_pend  <= 1'b0;
                r_mode  <= r_pend_mode;
                r_level <= r_pend_level;
            end else if (w_accept) begin
                r_pend       <= 1'b1;
                r_pend_mode  <= mode_e'(i_cmd_mode);
                r_pend_level <= i_cmd_level;
            end
            if (w_apply) begin
                r_phase <= 1'b1;
            end else if (w_blink_tick) begin
                r_phase <= ~r_phase;
            end
        end
    end

`ifdef LED_DRIVER_BREATHE_EN
    localparam int unsigned RampDiv = clamp_div(CLK_FREQ, 32'(1) << (PWM_BITS + 1));

    logic                w_ramp_tick;
    breathe_st_e         r_state;
    breathe_st_e         w_state_d;
    logic [PWM_BITS-1:0] r_ramp;
    logic [PWM_BITS-1:0] w_ramp_d;

    tick_gen #(
        .DIV(RampDiv)
    ) u_ramp_tick (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (w_apply),
        .o_tick(w_ramp_tick)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StRise;
            r_ramp  <= '0;
        end else begin
            r_state <= w_state_d;
            r_ramp  <= w_ramp_d;
        end
    end

    // Triangle ramp between 0 and the peak level; a zero peak parks the ramp at 0.
    always_comb begin
        w_state_d = r_state;
        w_ramp_d  = r_ramp;
        if (w_apply) begin
            w_state_d = StRise;
            w_ramp_d  = '0;
        end else if (w_ramp_tick && (r_mode == ModeBreathe)) begin
            case (r_state)
                StRise: begin
                    if (r_ramp != r_level) begin
                        w_ramp_d = r_ramp + 1'b1;
                        if (w_ramp_d == r_level) begin
                            w_state_d = StFall;
                        end
                    end
                end
                StFall: begin
                    if (r_ramp != '0) begin
                        w_ramp_d = r_ramp - 1'b1;
                        if (w_ramp_d == '0) begin
                            w_state_d = StRise;
                        end
                    end
                end
                default: begin
                    w_state_d = StRise;
                end
            endcase
        end
    end

    assign w_breathe_duty = r_ramp;
`else
    assign w_breathe_duty = r_level;
`endif

    always_comb begin
        w_duty = '0;
        case (r_mode)
            ModeOff:     w_duty = '0;
            ModeOn:      w_duty = r_level;
            ModeBlink:   w_duty = r_phase ? r_level : '0;
            ModeBreathe: w_duty = w_breathe_duty;
            default:     w_duty = '0;
        endcase
    end

    // Counter never reaches all-ones, so a full-scale duty yields a constant high.
    assign w_led_d = (r_cnt < w_duty);

endmodule

// File: doc/led_driver.md
LED_DRIVER -- requirements
Module: led_driver

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 25_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter PWM_BITS, default 8, brightness resolution.
REQ-003 SHALL have parameter BLINK_HZ, default 2, blink frequency in Hz.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 cmd_valid  input  1  command offered.
REQ-007 cmd_ready  output  1  driver can accept a command.
REQ-008 cmd_mode  input  2  00 OFF, 01 ON, 10 BLINK, 11 BREATHE.
REQ-009 cmd_level  input  PWM_BITS  peak brightness.
REQ-010 led  output  1  PWM LED drive, registered.

Function
REQ-011 Command SHALL be accepted on a cycle with cmd_valid and cmd_ready both high; mode and level captured into a pending register.
REQ-012 cmd_ready SHALL drop the cycle after acceptance and stay low until the pending command is applied.
REQ-013 PWM counter SHALL count 0..2^PWM_BITS-2 and wrap; a pending command SHALL be applied on the cycle the counter equals 2^PWM_BITS-2, effective from counter 0; cmd_ready SHALL rise the next cycle.
REQ-014 Raw PWM SHALL be (counter < duty); duty 0 gives constant 0, duty 2^PWM_BITS-1 gives constant 1.
REQ-015 OFF: led 0. ON: duty = level.
REQ-016 BLINK: phase toggles every CLK_FREQ/(2*BLINK_HZ) cycles; led = phase AND raw PWM; phase SHALL be 1 on apply.
REQ-017 BREATHE: FSM states RISE, FALL; duty steps by 1 every CLK_FREQ/2^(PWM_BITS+1) cycles; RISE->FALL when duty reaches level; FALL->RISE when duty reaches 0; entered at RISE with duty 0.
REQ-018 Applying any command SHALL clear the blink and ramp prescalers.
REQ-019 BREATHE with level 0 SHALL hold duty 0, led 0.
REQ-020 Re-applying an identical command SHALL restart phase/ramp (not ignored).
REQ-021 led SHALL be registered: one cycle after raw PWM comparison.
REQ-022 All prescaler divisions SHALL be integer; a result of 0 SHALL be clamped to 1.

Reset
REQ-023 rst asserted SHALL immediately force led 0, cmd_ready 1, mode OFF, level 0, duty 0, pending clear, all counters 0, FSM RISE, phase 1.
REQ-024 Reset mid-command SHALL discard the pending command.
REQ-025 First acceptance SHALL be possible on the first clock edge after rst deasserts.

Configuration
REQ-026 Macro LED_DRIVER_BREATHE_EN: defined, BREATHE per REQ-017; undefined, ramp prescaler and FSM SHALL be absent and mode 11 SHALL behave exactly as ON.

Structure
REQ-027 Package led_pkg SHALL hold the mode encoding constants (OFF, ON, BLINK, BREATHE), breathe FSM state encoding and default PWM_BITS.
REQ-028 One sub-module tick_gen (parameter DIV; inputs clk, rst, clr; output one-cycle tick) SHALL implement both prescalers.

Verification (CLK_FREQ=1024, PWM_BITS=4, BLINK_HZ=2: PWM period 15, blink half-period 256, ramp step 32)
REQ-029 Reset then ON level 15 -> cmd_ready low until counter 14 apply; led constant 1 afterwards.
REQ-030 ON level 5 -> led high 5 of every 15 cycles, no glitch across the apply boundary.
REQ-031 BLINK level 15 -> led high 256 cycles, low 256, repeating, starting high at apply.
REQ-032 BREATHE level 3 -> duty 0,1,2,3,2,1,0,1... each held 32 cycles; without LED_DRIVER_BREATHE_EN -> led equals ON level 3.
REQ-033 cmd_valid held high with two back-to-back commands -> second accepted only after first applied; cmd_ready low for 1-15 cycles each.
REQ-034 rst pulsed during BLINK with a pending command -> led 0 immediately, cmd_ready 1, pending ignored after release.
